// File: rtl/full_adder.sv
// full_adder: registered WIDTH-bit unsigned adder, {c_out, sum} = a + b + c_in.
//
// The sum is split into WIDTH/SEG segments. Each segment uses 4-bit carry-lookahead
// groups and produces two results, one for carry-in 0 and one for carry-in 1. Segment 0
// takes c_in directly. Every later segment picks one of its two results using the carry
// out of the segment below it (carry-select), so the only serial path between segments
// is a chain of muxes.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears sum, c_out and out_valid
//   in_valid   a, b and c_in are valid this cycle
//   a, b       WIDTH-bit unsigned operands
//   c_in       carry-in, weighted at the LSB
//   sum        low WIDTH bits of the registered result
//   c_out      carry out of bit WIDTH-1
//   out_valid  sum and c_out hold a new result this cycle
module full_adder #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned SEG   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             out_valid
);

  localparam int unsigned NumSeg = WIDTH / SEG;
  localparam int unsigned NumGrp = SEG / 4;

  // One segment built from 4-bit lookahead groups.
  // The carry into each group moves from group to group.
  // Inside a group, every carry is formed directly from p/g and the group carry-in.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    logic [SEG-1:0] p;
    logic [SEG-1:0] g;
    logic [SEG:0]   c;
    int unsigned    bs;
    p    = x ^ y;
    g    = x & y;
    c    = '0;
    c[0] = ci;
    for (int unsigned grp = 0; grp < NumGrp; grp++) begin
      bs = grp * 4;
      c[bs+1] = g[bs] | (p[bs] & c[bs]);
      c[bs+2] = g[bs+1] | (p[bs+1] & g[bs]) | (p[bs+1] & p[bs] & c[bs]);
      c[bs+3] = g[bs+2] | (p[bs+2] & g[bs+1]) | (p[bs+2] & p[bs+1] & g[bs])
              | (p[bs+2] & p[bs+1] & p[bs] & c[bs]);
      // Group generate and propagate give the carry out of the group.
      c[bs+4] = (g[bs+3] | (p[bs+3] & g[bs+2]) | (p[bs+3] & p[bs+2] & g[bs+1])
                 | (p[bs+3] & p[bs+2] & p[bs+1] & g[bs]))
              | (p[bs+3] & p[bs+2] & p[bs+1] & p[bs] & c[bs]);
    end
    return {c[SEG], p ^ c[SEG-1:0]};
  endfunction

  logic [WIDTH-1:0]  sum_d;
  logic              c_out_d;
  logic [NumSeg:0]   seg_carry;
  logic [SEG:0]      res0;
  logic [SEG:0]      res1;
  logic [SEG:0]      res_sel;

  logic [WIDTH-1:0]  sum_q;
  logic              c_out_q;
  logic              out_valid_q;

  always_comb begin
    sum_d        = '0;
    seg_carry    = '0;
    res0         = '0;
    res1         = '0;
    res_sel      = '0;
    seg_carry[0] = c_in;
    for (int unsigned k = 0; k < NumSeg; k++) begin
      if (k == 0) begin
        res_sel = cla_seg(a[0 +: SEG], b[0 +: SEG], c_in);
      end else begin
        // Both results depend only on the operands, so they are ready before the
        // carry from the lower segment is known.
        res0    = cla_seg(a[k*SEG +: SEG], b[k*SEG +: SEG], 1'b0);
        res1    = cla_seg(a[k*SEG +: SEG], b[k*SEG +: SEG], 1'b1);
        res_sel = seg_carry[k] ? res1 : res0;
      end
      sum_d[k*SEG +: SEG] = res_sel[SEG-1:0];
      seg_carry[k+1]      = res_sel[SEG];
    end
    c_out_d = seg_carry[NumSeg];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      // Without in_valid the old result stays, so X/Z on the operands cannot reach it.
      if (in_valid) begin
        sum_q   <= sum_d;
        c_out_q <= c_out_d;
      end
    end
  end

  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

  localparam int unsigned W = 128;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic [W-1:0] sum;
  logic         c_out;
  logic         out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  full_adder #(.WIDTH(W), .SEG(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sum       (sum),
    .c_out     (c_out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer addition at WIDTH+1 bits.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction

  // Called at a negedge. The next posedge captures these operands, and the result can be
  // read at the negedge that follows.
  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    a        = x;
    b        = y;
    c_in     = ci;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(128'd5, 128'd7, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({c_out, sum} !== {(W+1){1'b0}} || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got c_out=%b sum=%h ov=%b, want all 0", c_out, sum, out_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (sum !== 128'd12 || c_out !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got c_out=%b sum=%h ov=%b, want 0/c/1",
               c_out, sum, out_valid);
    end
  endtask

  // Each entry is {a, b, c_in}. Every result is checked against the reference model.
  task automatic run_vectors(input string name, input logic [W-1:0] va[$],
                             input logic [W-1:0] vb[$], input logic vc[$]);
    logic [W:0] exp_v;
    for (int i = 0; i < va.size(); i++) begin
      drive(va[i], vb[i], vc[i]);
      exp_v = ref_add(va[i], vb[i], vc[i]);
      @(negedge clk);
      n_tests++;
      if ({c_out, sum} !== exp_v || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s[%0d]: got c_out=%b sum=%h ov=%b, want c_out=%b sum=%h ov=1",
                 name, i, c_out, sum, out_valid, exp_v[W], exp_v[W-1:0]);
      end
    end
  endtask

  task automatic test_carry_ripple();
    logic [W-1:0] ones;
    ones = '1;
    // Also check the expected values against known constants.
    n_tests++;
    if (ref_add(ones, '0, 1'b1) !== {1'b1, {W{1'b0}}}) begin
      n_fail++;
      $display("FAIL ref_ripple: got %h, want 1_000..0", ref_add(ones, '0, 1'b1));
    end
    run_vectors("carry_ripple", '{ones, ones}, '{128'd0, 128'd0}, '{1'b1, 1'b0});
  endtask

  task automatic test_segment_boundary();
    logic [W-1:0] m32;
    logic [W-1:0] m64;
    logic [W-1:0] m96;
    m32 = {96'd0, {32{1'b1}}};
    m64 = {64'd0, {64{1'b1}}};
    m96 = {32'd0, {96{1'b1}}};
    run_vectors("seg_boundary", '{m32, m64, m96}, '{128'd1, 128'd1, 128'd1},
                '{1'b0, 1'b0, 1'b0});
  endtask

  task automatic test_max_operands();
    logic [W-1:0] ones;
    ones = '1;
    n_tests++;
    if (ref_add(ones, ones, 1'b0) !== {1'b1, ones - 128'd1}) begin
      n_fail++;
      $display("FAIL ref_max: got %h, want 1_ff..fe", ref_add(ones, ones, 1'b0));
    end
    run_vectors("max_operands", '{ones, ones}, '{ones, ones}, '{1'b1, 1'b0});
  endtask

  // Operands change every cycle. Expected results wait in a queue.
  task automatic test_back_to_back();
    logic [W:0]   exp_q[$];
    logic [W:0]   exp_v;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         ci;
    for (int i = 0; i <= 100; i++) begin
      if (i > 0) begin
        exp_v = exp_q.pop_front();
        n_tests++;
        if ({c_out, sum} !== exp_v || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL random[%0d]: got c_out=%b sum=%h ov=%b, want c_out=%b sum=%h ov=1",
                   i - 1, c_out, sum, out_valid, exp_v[W], exp_v[W-1:0]);
        end
      end
      if (i < 100) begin
        x  = rand_word();
        y  = rand_word();
        ci = 1'(  $urandom_range(1));
        // Sometimes use y = ~x so that carries run through long stretches of bits.
        if ($urandom_range(7) == 0) y = ~x;
        drive(x, y, ci);
        exp_q.push_back(ref_add(x, y, ci));
        @(negedge clk);
      end
    end
  endtask

  task automatic test_hold_async_reset();
    logic [W:0] exp_v;
    drive(128'h1234_5678_9abc_def0_0fed_cba9_8765_4321, 128'hffff_0000_ffff_0000_1111_2222_3333_4444,
          1'b1);
    exp_v = ref_add(a, b, c_in);
    @(negedge clk);
    in_valid = 1'b0;
    a        = 'x;
    b        = rand_word();
    c_in     = 1'bz;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({c_out, sum} !== exp_v || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold: got c_out=%b sum=%h ov=%b, want c_out=%b sum=%h ov=0",
               c_out, sum, out_valid, exp_v[W], exp_v[W-1:0]);
    end
    // A new operation is in flight. Reset comes between edges and discards it.
    drive(rand_word(), rand_word(), 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({c_out, sum} !== {(W+1){1'b0}} || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got c_out=%b sum=%h ov=%b, want all 0",
               c_out, sum, out_valid);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if ({c_out, sum} !== {(W+1){1'b0}} || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard: got c_out=%b sum=%h ov=%b, want all 0",
               c_out, sum, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_vectors("post_reset", '{128'd100}, '{128'd23}, '{1'b1});
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    c_in     = 1'b0;
    test_reset();
    test_carry_ripple();
    test_segment_boundary();
    test_max_operands();
    test_back_to_back();
    test_hold_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- 128-bit binary adder with carry-in and carry-out, registered at the output.
- Computes {c_out, sum} = a + b + c_in.
- Used as the wide-datapath addition primitive.
- Internally built from carry-lookahead segments joined by carry-select, so the full width closes timing in one cycle.

Parameters:
- WIDTH, 128, operand and sum width in bits; must be a multiple of SEG.
- SEG, 32, width of each internal carry-lookahead/carry-select segment.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands on a/b/c_in are valid this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- c_in  input  1  carry-in, LSB-weighted
- sum  output  WIDTH  low WIDTH bits of a+b+c_in
- c_out  output  1  carry out of bit WIDTH-1
- out_valid  output  1  sum/c_out hold a new result

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset:
  - rst_n low immediately forces sum=0, c_out=0, out_valid=0, independent of clk.
  - Deassertion is synchronised by the integrating design.
  - No result is produced from operands presented while rst_n is low.
- Arithmetic:
  - Unsigned addition; {c_out, sum} = a + b + c_in, exact modulo 2^(WIDTH+1).
  - There is no overflow flag; c_out is the only overflow indication.
- Latency: one cycle.
  - On a rising clk edge with in_valid=1, the result of the sampled a/b/c_in is registered into sum/c_out, and out_valid=1 in the following cycle.
- Hold:
  - On a rising edge with in_valid=0, sum/c_out keep their previous values and out_valid goes to 0.
  - Results are never lost; there is no backpressure, so the consumer must take the result when out_valid=1.
- Throughput: one addition per cycle; back-to-back in_valid produces back-to-back out_valid.
- Structure (required, fixed):
  - WIDTH/SEG segments; each segment computes 4-bit-group carry-lookahead sums for both carry-in=0 and carry-in=1.
  - Segment 0 uses c_in directly; segment k selects by the resolved carry from segment k-1.
  - Result must be bit-identical to a behavioural a+b+c_in.
- Boundary conditions:
  - All-ones + 0 + c_in=1 gives full carry ripple across every segment boundary: sum=0, c_out=1.
  - All-ones + all-ones + 1 gives sum=all-ones, c_out=1.
  - X/Z on inputs when in_valid=0 must not disturb outputs.
  - Reset asserted mid-stream clears outputs at once; the in-flight result is discarded.

Test Plan:
1. Reset: hold rst_n=0 with in_valid=1, a=5, b=7 across edges -> sum=0, c_out=0, out_valid=0. Release reset, next edge -> sum=12, c_out=0, out_valid=1.
2. Full carry propagation: a=2^128-1, b=0, c_in=1 -> one cycle later sum=0, c_out=1. Repeat with c_in=0 -> sum=2^128-1, c_out=0.
3. Segment boundary: a=2^32-1, b=1, c_in=0 -> sum=2^32, c_out=0. Also a=2^96-1, b=1 -> sum=2^96.
4. Maximum operands: a=b=2^128-1, c_in=1 -> sum=2^128-1, c_out=1. With c_in=0 -> sum=2^128-2, c_out=1.
5. Random regression:
   - 100 cycles of random 128-bit a, b and random c_in with in_valid=1.
   - Compare each result one cycle later against the behavioural {c_out, sum} = a+b+c_in using case-equality (no X allowed).
   - out_valid=1 every cycle.
6. Hold and async reset:
   - After a result, drop in_valid and change a/b -> sum/c_out unchanged, out_valid=0.
   - Pulse rst_n low between edges -> outputs go to 0 immediately, before the next clk edge.
